tt_um_matmul_sequencer: RTL and testbench

Serial-load, time-shared controller for the 2x2 unsigned matrix-multiply datapath. It accepts the eight 2-bit elements of A and B one per cycle over a narrow input bus and sequences a single shared 2x2-bit multiplier and 5-bit accumulator over eight steps. It then streams the four results out under a valid/ready handshake. It sits at the Tiny Tapeout user-project boundary and frees the uio pins for status.

---
 rtl/tt_um_matmul_sequencer.sv | 156 +++++++++++++++
 tb/tb_tt_um_matmul_sequencer.sv | 281 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/tt_um_matmul_sequencer.sv
// Serial-load 2x2 unsigned matrix multiplier: one shared 2x2-bit multiplier and
// a 5-bit accumulator are stepped over eight cycles, then results stream out via valid/ready.
module tt_um_matmul_sequencer (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ena,
  input  logic [7:0] ui_in,
  input  logic [7:0] uio_in,
  output logic [7:0] uo_out,
  output logic [7:0] uio_out,
  output logic [7:0] uio_oe
);

  typedef enum logic [1:0] {
    ST_LOAD    = 2'd0,
    ST_COMPUTE = 2'd1,
    ST_OUTPUT  = 2'd2
  } state_e;

  state_e     state_q, state_d;
  logic [3:0] load_cnt_q, load_cnt_d;
  logic [2:0] step_q, step_d;
  logic [1:0] out_idx_q, out_idx_d;
  logic [4:0] acc_q, acc_d;
  logic       err_q, err_d;

  logic [1:0] elem_q [8];
  logic [4:0] result_q [4];

  logic       elem_we;
  logic       res_we;
  logic [4:0] res_wdata;

  logic [1:0] elem_data;
  logic       load_valid, start, res_ready, clear;
  logic       load_full;
  logic       unused_inputs;

  assign elem_data     = ui_in[1:0];
  assign load_valid    = ui_in[2];
  assign start         = ui_in[3];
  assign res_ready     = ui_in[4];
  assign clear         = ui_in[5];
  assign unused_inputs = ^{uio_in, ui_in[7:6]};

  assign load_full = (load_cnt_q == 4'd8);

  // step = {row, col, term}; term picks A column / B row (k=1 or k=2)
  logic       row, col, term;
  logic [1:0] mul_a, mul_b;
  logic [3:0] product;
  logic [4:0] sum;

  assign row     = step_q[2];
  assign col     = step_q[1];
  assign term    = step_q[0];
  assign mul_a   = elem_q[{1'b0, row, term}];
  assign mul_b   = elem_q[{1'b1, term, col}];
  assign product = {2'b00, mul_a} * {2'b00, mul_b};
  assign sum     = acc_q + {1'b0, product};

  always_comb begin
    state_d    = state_q;
    load_cnt_d = load_cnt_q;
    step_d     = step_q;
    out_idx_d  = out_idx_q;
    acc_d      = acc_q;
    err_d      = err_q;
    elem_we    = 1'b0;
    res_we     = 1'b0;
    res_wdata  = sum;
    if (clear) begin
      state_d    = ST_LOAD;
      load_cnt_d = 4'd0;
      step_d     = 3'd0;
      out_idx_d  = 2'd0;
      acc_d      = 5'd0;
      err_d      = 1'b0;
    end else begin
      case (state_q)
        ST_LOAD: begin
          if (load_valid && !load_full) begin
            elem_we    = 1'b1;
            load_cnt_d = load_cnt_q + 4'd1;
          end
          // start is judged on the count before this edge's store
          if (start) begin
            if (load_full) begin
              state_d = ST_COMPUTE;
              step_d  = 3'd0;
            end else begin
              err_d = 1'b1;
            end
          end
        end
        ST_COMPUTE: begin
          if (!term) begin
            acc_d = {1'b0, product};
          end else begin
            res_we = 1'b1;
          end
          step_d = step_q + 3'd1;
          if (step_q == 3'd7) begin
            state_d   = ST_OUTPUT;
            out_idx_d = 2'd0;
          end
        end
        ST_OUTPUT: begin
          if (res_ready) begin
            if (out_idx_q == 2'd3) begin
              state_d    = ST_LOAD;
              load_cnt_d = 4'd0;
              out_idx_d  = 2'd0;
            end else begin
              out_idx_d = out_idx_q + 2'd1;
            end
          end
        end
        default: state_d = ST_LOAD;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= ST_LOAD;
      load_cnt_q <= 4'd0;
      step_q     <= 3'd0;
      out_idx_q  <= 2'd0;
      acc_q      <= 5'd0;
      err_q      <= 1'b0;
    end else if (ena) begin
      state_q    <= state_d;
      load_cnt_q <= load_cnt_d;
      step_q     <= step_d;
      out_idx_q  <= out_idx_d;
      acc_q      <= acc_d;
      err_q      <= err_d;
    end
  end

  // Operand and result storage is never reset; it is simply overwritten.
  always_ff @(posedge clk) begin
    if (rst_n && ena && elem_we) begin
      elem_q[load_cnt_q[2:0]] <= elem_data;
    end
    if (rst_n && ena && res_we) begin
      result_q[step_q[2:1]] <= res_wdata;
    end
  end

  assign uo_out  = (state_q == ST_OUTPUT) ? {1'b1, out_idx_q, result_q[out_idx_q]} : 8'h00;
  assign uio_out = {3'b000, err_q, load_full, (state_q != ST_LOAD), state_q};
  assign uio_oe  = 8'hFF;

endmodule

// File: tb/tb_tt_um_matmul_sequencer.sv
// Bench for tt_um_matmul_sequencer: directed scenarios plus random traffic, checked
// every cycle against a matrix-level model of the sequencer.
module tb_tt_um_matmul_sequencer;

  logic       clk = 1'b0;
  logic       rst_n, ena;
  logic [1:0] d;
  logic       lv, st, rr, clr;
  logic [7:0] uio_in_s;
  logic [7:0] ui_in;
  logic [7:0] uo_out, uio_out, uio_oe;

  assign ui_in = {2'b00, clr, rr, st, lv, d};

  always #5 clk = ~clk;

  tt_um_matmul_sequencer dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .ena    (ena),
    .ui_in  (ui_in),
    .uio_in (uio_in_s),
    .uo_out (uo_out),
    .uio_out(uio_out),
    .uio_oe (uio_oe)
  );

  int total = 0;
  int bad   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // model: phase 0=LOAD 1=COMPUTE 2=OUTPUT
  int         m_phase, m_cnt, m_k, m_oi;
  bit         m_err;
  int         m_elem [8];
  int         m_c [4];
  bit         m_init = 0;
  logic [7:0] last_uo = 8'h00;
  logic [7:0] xfers[$];

  logic [7:0] nom_exp [4] = '{8'h84, 8'hA7, 8'hC6, 8'hE3};
  int nom_v [8] = '{1, 2, 3, 0, 2, 1, 1, 3};
  int max_v [8] = '{3, 3, 3, 3, 3, 3, 3, 3};

  initial begin
    logic       s_rst, s_ena;
    logic [7:0] s_ui;
    logic [7:0] exp_uo, exp_uio;
    int         old_cnt;
    forever begin
      @(posedge clk);
      s_rst = rst_n;
      s_ena = ena;
      s_ui  = ui_in;
      if (m_init && s_rst && s_ena && !s_ui[5] && last_uo[7] && s_ui[4])
        xfers.push_back(last_uo);
      if (!s_rst) begin
        m_phase = 0; m_cnt = 0; m_k = 0; m_oi = 0; m_err = 0; m_init = 1;
      end else if (m_init && s_ena) begin
        if (s_ui[5]) begin
          m_phase = 0; m_cnt = 0; m_k = 0; m_oi = 0; m_err = 0;
        end else begin
          case (m_phase)
            0: begin
              old_cnt = m_cnt;
              if (s_ui[2] && m_cnt < 8) begin
                m_elem[m_cnt] = int'(s_ui[1:0]);
                m_cnt++;
              end
              if (s_ui[3]) begin
                if (old_cnt == 8) begin
                  m_phase = 1;
                  m_k = 0;
                  for (int i = 0; i < 2; i++)
                    for (int j = 0; j < 2; j++)
                      m_c[i*2+j] = m_elem[i*2] * m_elem[4+j] + m_elem[i*2+1] * m_elem[6+j];
                end else begin
                  m_err = 1;
                end
              end
            end
            1: begin
              m_k++;
              if (m_k == 8) begin
                m_phase = 2;
                m_oi = 0;
              end
            end
            default: begin
              if (s_ui[4]) begin
                if (m_oi == 3) begin
                  m_phase = 0;
                  m_cnt = 0;
                end else begin
                  m_oi++;
                end
              end
            end
          endcase
        end
      end
      #1;
      if (m_init) begin
        exp_uo  = (m_phase == 2) ? {1'b1, m_oi[1:0], m_c[m_oi][4:0]} : 8'h00;
        exp_uio = {3'b000, m_err, (m_cnt == 8), (m_phase != 0), m_phase[1:0]};
        chk("uo_out", {24'd0, uo_out}, {24'd0, exp_uo});
        chk("uio_out", {24'd0, uio_out}, {24'd0, exp_uio});
        chk("uio_oe", {24'd0, uio_oe}, 32'hFF);
      end
      last_uo = uo_out;
    end
  end

  task automatic cyc();
    @(negedge clk);
  endtask

  task automatic load_n(input int v[8], input int first, input int n);
    for (int i = first; i < first + n; i++) begin
      lv = 1'b1;
      d  = 2'(v[i]);
      cyc();
    end
    lv = 1'b0;
  endtask

  task automatic start_and_wait(output int lat);
    st = 1'b1;
    cyc();
    st = 1'b0;
    lat = 0;
    while (!uo_out[7] && lat < 40) begin
      cyc();
      lat++;
    end
  endtask

  task automatic chk_nom(input string tag);
    chk({tag, "_count"}, xfers.size(), 4);
    for (int i = 0; i < xfers.size() && i < 4; i++)
      chk(tag, {24'd0, xfers[i]}, {24'd0, nom_exp[i]});
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat;
    rst_n = 1'b0; ena = 1'b1; d = 2'd0; lv = 1'b0; st = 1'b0; rr = 1'b0; clr = 1'b0;
    uio_in_s = 8'h00;
    cyc();
    chk("reset_uo", {24'd0, uo_out}, 32'h00);
    chk("reset_uio", {24'd0, uio_out}, 32'h00);
    cyc();
    rst_n = 1'b1;
    cyc();

    // nominal
    rr = 1'b1;
    xfers.delete();
    load_n(nom_v, 0, 8);
    start_and_wait(lat);
    chk("nom_latency", lat, 8);
    repeat (4) cyc();
    chk_nom("nom_results");
    chk("nom_after_uio", {24'd0, uio_out}, 32'h00);

    // all-max operands
    xfers.delete();
    load_n(max_v, 0, 8);
    start_and_wait(lat);
    repeat (4) cyc();
    chk("max_count", xfers.size(), 4);
    for (int i = 0; i < xfers.size() && i < 4; i++) begin
      chk("max_value", {27'd0, xfers[i][4:0]}, 32'd18);
      chk("max_index", {30'd0, xfers[i][6:5]}, i);
    end

    // back-pressure
    rr = 1'b0;
    xfers.delete();
    load_n(nom_v, 0, 8);
    start_and_wait(lat);
    repeat (5) begin
      cyc();
      chk("stall_hold", {24'd0, uo_out}, 32'h84);
    end
    for (int r = 0; r < 4; r++) begin
      rr = 1'b1; cyc();
      rr = 1'b0; cyc();
    end
    chk_nom("bp_results");

    // early start
    clr = 1'b1; cyc(); clr = 1'b0;
    load_n(nom_v, 0, 5);
    lv = 1'b1; st = 1'b1; d = 2'(nom_v[5]);
    cyc();
    lv = 1'b0; st = 1'b0;
    chk("early_err", {31'd0, uio_out[4]}, 1);
    chk("early_state", {30'd0, uio_out[1:0]}, 0);
    load_n(nom_v, 6, 2);
    chk("early_full", {31'd0, uio_out[3]}, 1);
    xfers.delete();
    rr = 1'b1;
    start_and_wait(lat);
    chk("early_latency", lat, 8);
    chk("early_err_kept", {31'd0, uio_out[4]}, 1);
    repeat (4) cyc();
    chk_nom("early_results");
    clr = 1'b1; cyc(); clr = 1'b0;
    chk("early_cleared", {31'd0, uio_out[4]}, 0);

    // clear mid-compute
    load_n(nom_v, 0, 8);
    st = 1'b1; cyc(); st = 1'b0;
    repeat (3) cyc();
    clr = 1'b1; cyc(); clr = 1'b0;
    chk("abort_uo", {24'd0, uo_out}, 32'h00);
    chk("abort_busy", {31'd0, uio_out[2]}, 0);
    chk("abort_state", {30'd0, uio_out[1:0]}, 0);

    // ena hold mid-compute
    xfers.delete();
    load_n(nom_v, 0, 8);
    st = 1'b1; cyc(); st = 1'b0;
    cyc(); cyc();
    ena = 1'b0;
    repeat (4) cyc();
    ena = 1'b1;
    lat = 6;
    while (!uo_out[7] && lat < 40) begin
      cyc();
      lat++;
    end
    chk("ena_latency", lat, 12);
    repeat (4) cyc();
    chk_nom("ena_results");

    // reset beats clear and ena
    rr = 1'b0;
    load_n(nom_v, 0, 8);
    start_and_wait(lat);
    rst_n = 1'b0; clr = 1'b1; ena = 1'b0;
    cyc();
    chk("rst_uo", {24'd0, uo_out}, 32'h00);
    chk("rst_uio", {24'd0, uio_out}, 32'h00);
    chk("rst_oe", {24'd0, uio_oe}, 32'hFF);
    rst_n = 1'b1; clr = 1'b0; ena = 1'b1;
    cyc();

    // random traffic
    repeat (600) begin
      d        = 2'($urandom_range(0, 3));
      lv       = ($urandom_range(0, 1) == 1);
      st       = ($urandom_range(0, 5) == 0);
      rr       = ($urandom_range(0, 2) != 0);
      clr      = ($urandom_range(0, 40) == 0);
      ena      = ($urandom_range(0, 7) != 0);
      rst_n    = ($urandom_range(0, 150) != 0);
      uio_in_s = 8'($urandom);
      cyc();
    end
    rst_n = 1'b1; ena = 1'b1; lv = 1'b0; st = 1'b0; clr = 1'b0;
    repeat (3) cyc();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
